// File: rtl/serv_decode_queue.sv
// serv_decode_queue
// Instruction pre-decode FIFO between the instruction bus and the SERV decoder.
// Bus words (instruction bits 31:2) are buffered in a DEPTH-entry queue, and the
// head entry is presented with a small set of decoded control flags behind a
// valid/ready handshake. Adds flush, sticky overflow and an illegal-opcode flag.
// DEPTH must be a power of two and at least 2, so the pointers wrap naturally.

module serv_decode_queue #(
    parameter int DEPTH        = 4,
    parameter bit MDU          = 1'b0,
    parameter bit PRE_REGISTER = 1'b1
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic [29:0]                i_wb_rdt,
    input  logic                       i_wb_en,
    input  logic                       i_flush,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [29:0]                o_rdt,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_overflow,
    output logic                       o_dbus_en,
    output logic                       o_mem_cmd,
    output logic                       o_branch_op,
    output logic                       o_csr_en,
    output logic                       o_mdu_op,
    output logic                       o_rd_op,
    output logic                       o_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Major opcodes, instruction bits 6:2
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_MISC   = 5'b00011;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    // Bit positions inside the packed flag vector
    localparam int F_DBUS    = 6;
    localparam int F_MEM_CMD = 5;
    localparam int F_BRANCH  = 4;
    localparam int F_CSR     = 3;
    localparam int F_MDU     = 2;
    localparam int F_RD      = 1;
    localparam int F_ILLEGAL = 0;

    // Decode one bus word (bits 31:2 of the instruction) into the packed flags.
    // Word index = instruction bit - 2.
    function automatic logic [6:0] decode_word(input logic [29:0] w);
        logic [4:0] op;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic       bit25;
        logic       is_load;
        logic       is_store;
        logic       is_misc;
        logic       is_op;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_system;
        logic       is_legal;
        logic       is_muldiv;
        logic [6:0] f;
        op        = w[4:0];
        rd        = w[9:5];
        funct3    = w[12:10];
        bit25     = w[23];
        is_load   = (op == OP_LOAD);
        is_store  = (op == OP_STORE);
        is_misc   = (op == OP_MISC);
        is_op     = (op == OP_OP);
        is_branch = (op == OP_BRANCH);
        is_jal    = (op == OP_JAL);
        is_jalr   = (op == OP_JALR);
        is_system = (op == OP_SYSTEM);
        is_legal  = is_load | is_misc | (op == OP_OPIMM) | (op == OP_AUIPC) |
                    is_store | is_op | (op == OP_LUI) | is_branch |
                    is_jalr | is_jal | is_system;
        is_muldiv = is_op & bit25;
        f            = '0;
        f[F_DBUS]    = is_load | is_store;
        f[F_MEM_CMD] = is_store;
        f[F_BRANCH]  = is_branch | is_jal | is_jalr;
        f[F_CSR]     = is_system & (funct3 != 3'd0);
        f[F_MDU]     = MDU & is_muldiv;
        f[F_RD]      = (rd != 5'd0) &
                       !(is_store | is_branch | is_misc | (is_system & (funct3 == 3'd0)));
        f[F_ILLEGAL] = !is_legal | (!MDU & is_muldiv);
        return f;
    endfunction

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [29:0]   mem_q [DEPTH];
    logic [6:0]    head_flags;
    logic [29:0]   head_word;

    logic          valid;
    logic          full;
    logic          push;
    logic          pop;

    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = valid & i_ready & !i_flush;
    assign push  = i_wb_en & !i_flush & (!full | pop);

    // Next-state for pointers, occupancy and the sticky overflow flag; flush wins over everything
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (i_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (i_wb_en & full & !pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state registers, asynchronously cleared
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Word storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_wb_rdt;
        end
    end

    assign head_word = mem_q[rd_ptr_q];

    generate
        if (PRE_REGISTER) begin : g_pre_decode
            logic [6:0] flags_mem_q [DEPTH];

            // Decode on the way in and store the flags alongside each word
            always_ff @(posedge clk) begin
                if (push) begin
                    flags_mem_q[wr_ptr_q] <= decode_word(i_wb_rdt);
                end
            end

            assign head_flags = flags_mem_q[rd_ptr_q];
        end else begin : g_post_decode
            // Decode the head word directly on the read side
            always_comb begin
                head_flags = decode_word(head_word);
            end
        end
    endgenerate

    assign o_valid     = valid;
    assign o_rdt       = valid ? head_word : 30'd0;
    assign o_count     = count_q;
    assign o_full      = full;
    assign o_overflow  = overflow_q;
    assign o_dbus_en   = valid & head_flags[F_DBUS];
    assign o_mem_cmd   = valid & head_flags[F_MEM_CMD];
    assign o_branch_op = valid & head_flags[F_BRANCH];
    assign o_csr_en    = valid & head_flags[F_CSR];
    assign o_mdu_op    = valid & head_flags[F_MDU];
    assign o_rd_op     = valid & head_flags[F_RD];
    assign o_illegal   = valid & head_flags[F_ILLEGAL];

endmodule

// File: tb/tb_serv_decode_queue.sv
// Directed bench for serv_decode_queue. Two instances share one stimulus:
// dutA is MDU=0 with pre-registered flags, dutB is MDU=1 with read-side decode.
// Flag vectors are packed {dbus_en, mem_cmd, branch_op, csr_en, mdu_op, rd_op, illegal}.

module tb_serv_decode_queue;

    logic        clk;
    logic        i_rst_n;
    logic [29:0] i_wb_rdt;
    logic        i_wb_en;
    logic        i_flush;
    logic        i_ready;

    logic        aValid, aFull, aOverflow;
    logic [29:0] aRdt;
    logic [2:0]  aCount;
    logic        aDbus, aMem, aBranch, aCsr, aMdu, aRd, aIll;
    logic        bValid, bFull, bOverflow;
    logic [29:0] bRdt;
    logic [2:0]  bCount;
    logic        bDbus, bMem, bBranch, bCsr, bMdu, bRd, bIll;

    logic [6:0]  aFlags, bFlags;
    assign aFlags = {aDbus, aMem, aBranch, aCsr, aMdu, aRd, aIll};
    assign bFlags = {bDbus, bMem, bBranch, bCsr, bMdu, bRd, bIll};

    int vectors;
    int miscompares;

    // Words are instruction bits 31:2 (raw >> 2)
    localparam logic [29:0] W_LW    = 30'h0000_0020;  // lw   x1,0(x0)    0x00000083
    localparam logic [29:0] W_SW    = 30'h0008_0808;  // sw   x2,0(x0)    0x00202023
    localparam logic [29:0] W_BEQ   = 30'h0000_0018;  // beq  x0,x0,0     0x00000063
    localparam logic [29:0] W_JAL   = 30'h0000_003B;  // jal  x1,0        0x000000EF
    localparam logic [29:0] W_ADDI  = 30'h0004_0024;  // addi x1,x0,1     0x00100093
    localparam logic [29:0] W_ECALL = 30'h0000_001C;  // ecall            0x00000073
    localparam logic [29:0] W_MUL   = 30'h008C_402C;  // mul  x1,x2,x3    0x023100B3
    localparam logic [29:0] W_BAD   = 30'h0000_001F;  // opcode 11111     0x0000007F
    localparam logic [29:0] W_CSRRW = 30'h0000_043C;  // csrrw x1,0,x0    0x000010F3

    localparam logic [6:0] F_NONE  = 7'b0000000;
    localparam logic [6:0] F_LW    = 7'b1000010;
    localparam logic [6:0] F_SW    = 7'b1100000;
    localparam logic [6:0] F_BEQ   = 7'b0010000;
    localparam logic [6:0] F_JAL   = 7'b0010010;
    localparam logic [6:0] F_ADDI  = 7'b0000010;
    localparam logic [6:0] F_MUL_A = 7'b0000011;
    localparam logic [6:0] F_MUL_B = 7'b0000110;
    localparam logic [6:0] F_BAD   = 7'b0000001;
    localparam logic [6:0] F_CSRRW = 7'b0001010;

    serv_decode_queue #(.DEPTH(4), .MDU(1'b0), .PRE_REGISTER(1'b1)) dutA (
        .clk(clk), .i_rst_n(i_rst_n), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en),
        .i_flush(i_flush), .i_ready(i_ready),
        .o_valid(aValid), .o_rdt(aRdt), .o_count(aCount), .o_full(aFull),
        .o_overflow(aOverflow), .o_dbus_en(aDbus), .o_mem_cmd(aMem),
        .o_branch_op(aBranch), .o_csr_en(aCsr), .o_mdu_op(aMdu),
        .o_rd_op(aRd), .o_illegal(aIll)
    );

    serv_decode_queue #(.DEPTH(4), .MDU(1'b1), .PRE_REGISTER(1'b0)) dutB (
        .clk(clk), .i_rst_n(i_rst_n), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en),
        .i_flush(i_flush), .i_ready(i_ready),
        .o_valid(bValid), .o_rdt(bRdt), .o_count(bCount), .o_full(bFull),
        .o_overflow(bOverflow), .o_dbus_en(bDbus), .o_mem_cmd(bMem),
        .o_branch_op(bBranch), .o_csr_en(bCsr), .o_mdu_op(bMdu),
        .o_rd_op(bRd), .o_illegal(bIll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Full port check on both instances
    task automatic checkHead(input string tag, input logic expValid, input logic [29:0] expRdt,
                             input logic [2:0] expCount, input logic expFull,
                             input logic expOvf, input logic [6:0] expFa,
                             input logic [6:0] expFb);
        checkOutput({tag, ".a.valid"},    32'(aValid),    32'(expValid));
        checkOutput({tag, ".a.rdt"},      32'(aRdt),      32'(expRdt));
        checkOutput({tag, ".a.count"},    32'(aCount),    32'(expCount));
        checkOutput({tag, ".a.full"},     32'(aFull),     32'(expFull));
        checkOutput({tag, ".a.overflow"}, 32'(aOverflow), 32'(expOvf));
        checkOutput({tag, ".a.flags"},    32'(aFlags),    32'(expFa));
        checkOutput({tag, ".b.valid"},    32'(bValid),    32'(expValid));
        checkOutput({tag, ".b.rdt"},      32'(bRdt),      32'(expRdt));
        checkOutput({tag, ".b.count"},    32'(bCount),    32'(expCount));
        checkOutput({tag, ".b.full"},     32'(bFull),     32'(expFull));
        checkOutput({tag, ".b.overflow"}, 32'(bOverflow), 32'(expOvf));
        checkOutput({tag, ".b.flags"},    32'(bFlags),    32'(expFb));
    endtask

    // Drive one cycle of inputs, let the edge pass, then return inputs to idle
    task automatic applyStimulus(input logic wbEn, input logic [29:0] word,
                                 input logic ready, input logic flush);
        i_wb_en  = wbEn;
        i_wb_rdt = word;
        i_ready  = ready;
        i_flush  = flush;
        @(posedge clk);
        #1;
        i_wb_en  = 1'b0;
        i_ready  = 1'b0;
        i_flush  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        i_rst_n  = 1'b0;
        i_wb_rdt = '0;
        i_wb_en  = 1'b0;
        i_flush  = 1'b0;
        i_ready  = 1'b0;

        // Reset state
        #12;
        checkHead("reset", 1'b0, 30'd0, 3'd0, 1'b0, 1'b0, F_NONE, F_NONE);
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No same-cycle bypass into an empty queue
        i_wb_en  = 1'b1;
        i_wb_rdt = W_LW;
        #1;
        checkOutput("nobypass.a.valid", 32'(aValid), 32'd0);
        checkOutput("nobypass.b.valid", 32'(bValid), 32'd0);
        applyStimulus(1'b1, W_LW, 1'b0, 1'b0);
        checkHead("lw", 1'b1, W_LW, 3'd1, 1'b0, 1'b0, F_LW, F_LW);

        // Fill to DEPTH
        applyStimulus(1'b1, W_SW, 1'b0, 1'b0);
        applyStimulus(1'b1, W_BEQ, 1'b0, 1'b0);
        applyStimulus(1'b1, W_JAL, 1'b0, 1'b0);
        checkHead("fill4", 1'b1, W_LW, 3'd4, 1'b1, 1'b0, F_LW, F_LW);

        // Push and pop together at full: accepted, count unchanged
        applyStimulus(1'b1, W_ADDI, 1'b1, 1'b0);
        checkHead("fullpp", 1'b1, W_SW, 3'd4, 1'b1, 1'b0, F_SW, F_SW);

        // Write at full without pop is dropped and sets overflow
        applyStimulus(1'b1, W_ECALL, 1'b0, 1'b0);
        checkHead("drop", 1'b1, W_SW, 3'd4, 1'b1, 1'b1, F_SW, F_SW);

        // Drain across the pointer wrap; the word accepted at full comes out 4th
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkHead("pop1", 1'b1, W_BEQ, 3'd3, 1'b0, 1'b1, F_BEQ, F_BEQ);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkHead("pop2", 1'b1, W_JAL, 3'd2, 1'b0, 1'b1, F_JAL, F_JAL);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkHead("pop3", 1'b1, W_ADDI, 3'd1, 1'b0, 1'b1, F_ADDI, F_ADDI);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkHead("empty", 1'b0, 30'd0, 3'd0, 1'b0, 1'b1, F_NONE, F_NONE);

        // Flush with a simultaneous write clears everything
        applyStimulus(1'b1, W_LW, 1'b0, 1'b0);
        applyStimulus(1'b1, W_SW, 1'b0, 1'b0);
        applyStimulus(1'b1, W_BEQ, 1'b0, 1'b0);
        checkHead("three", 1'b1, W_LW, 3'd3, 1'b0, 1'b1, F_LW, F_LW);
        applyStimulus(1'b1, W_JAL, 1'b1, 1'b1);
        checkHead("flush", 1'b0, 30'd0, 3'd0, 1'b0, 1'b0, F_NONE, F_NONE);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkHead("postflush", 1'b0, 30'd0, 3'd0, 1'b0, 1'b0, F_NONE, F_NONE);

        // M-extension word: illegal without MDU, mdu_op with MDU
        applyStimulus(1'b1, W_MUL, 1'b0, 1'b0);
        checkHead("mul", 1'b1, W_MUL, 3'd1, 1'b0, 1'b0, F_MUL_A, F_MUL_B);

        // Single entry push+pop: valid stays high, new word next cycle
        applyStimulus(1'b1, W_BAD, 1'b1, 1'b0);
        checkHead("badop", 1'b1, W_BAD, 3'd1, 1'b0, 1'b0, F_BAD, F_BAD);
        applyStimulus(1'b1, W_CSRRW, 1'b1, 1'b0);
        checkHead("csrrw", 1'b1, W_CSRRW, 3'd1, 1'b0, 1'b0, F_CSRRW, F_CSRRW);
        applyStimulus(1'b1, W_ECALL, 1'b1, 1'b0);
        checkHead("ecall", 1'b1, W_ECALL, 3'd1, 1'b0, 1'b0, F_NONE, F_NONE);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkHead("drain", 1'b0, 30'd0, 3'd0, 1'b0, 1'b0, F_NONE, F_NONE);

        // Reset mid-stream: asynchronous clear, then normal operation
        applyStimulus(1'b1, W_LW, 1'b0, 1'b0);
        applyStimulus(1'b1, W_SW, 1'b0, 1'b0);
        applyStimulus(1'b1, W_ECALL, 1'b0, 1'b0);
        applyStimulus(1'b1, W_ECALL, 1'b0, 1'b0);
        applyStimulus(1'b1, W_ECALL, 1'b0, 1'b0);
        checkHead("prereset", 1'b1, W_LW, 3'd4, 1'b1, 1'b1, F_LW, F_LW);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkHead("asyncrst", 1'b0, 30'd0, 3'd0, 1'b0, 1'b0, F_NONE, F_NONE);
        #2;
        i_rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkHead("postrst", 1'b0, 30'd0, 3'd0, 1'b0, 1'b0, F_NONE, F_NONE);
        applyStimulus(1'b1, W_BEQ, 1'b0, 1'b0);
        checkHead("restart", 1'b1, W_BEQ, 3'd1, 1'b0, 1'b0, F_BEQ, F_BEQ);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serv_decode_queue.md
# serv_decode_queue

Parametrised instruction pre-decode queue between the instruction bus and the SERV decoder. It accepts 30-bit instruction words (bits 31:2) on bus strobes and buffers them in a DEPTH-entry FIFO. For the head entry it presents a small set of decoded control flags through a valid/ready handshake. It adds buffering, flush, overflow detection and an illegal-opcode flag, none of which the single-word decoder has.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- MDU, 0, 1 = M-extension opcodes legal and flagged on o_mdu_op
- PRE_REGISTER, 1, 1 = flags decoded at write and stored per entry; 0 = flags decoded combinationally from the head word. Port behaviour is identical for both settings.
- clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_wb_rdt  in  30  instruction bits 31:2
- i_wb_en  in  1  write strobe, one word per cycle
- i_flush  in  1  discard all entries (taken branch/trap)
- i_ready  in  1  consumer takes head entry
- o_valid  out  1  head entry present
- o_rdt  out  30  head instruction word
- o_count  out  $clog2(DEPTH)+1  entries held
- o_full  out  1  o_count == DEPTH
- o_overflow  out  1  sticky: a write was dropped
- o_dbus_en, o_mem_cmd, o_branch_op, o_csr_en, o_mdu_op, o_rd_op, o_illegal  out  1 each  decoded flags of head

## Operation
- Opcode op = rdt[6:2]; rd = rdt[11:7]; funct3 = rdt[14:12].
- Legal op values: LOAD 00000, MISC 00011, OPIMM 00100, AUIPC 00101, STORE 01000, OP 01100, LUI 01101, BRANCH 11000, JALR 11001, JAL 11011, SYSTEM 11100.
- o_dbus_en = LOAD|STORE; o_mem_cmd = STORE; o_branch_op = BRANCH|JAL|JALR.
- o_csr_en = SYSTEM & funct3≠0.
- o_mdu_op = MDU & OP & rdt[25].
- o_rd_op = rd≠0 & !(STORE|BRANCH|MISC|(SYSTEM & funct3==0)).
- o_illegal = op not legal | (MDU==0 & OP & rdt[25]).
- All flags and o_rdt are forced to 0 while o_valid=0.
- Push = i_wb_en & !i_flush & (!o_full | pop). Pop = o_valid & i_ready & !i_flush.
- Write when full without a pop: the word is dropped and o_overflow is set. o_overflow clears only on reset or i_flush.
- i_flush: read/write pointers and count go to 0 and o_overflow clears. A write or pop in the same cycle is ignored.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. The count tracks occupancy with +1/−1/0 for push/pop/both.

## Timing
- Reset (async assert, deassert synchronous to clk): pointers=0, o_count=0, o_valid=0, o_full=0, o_overflow=0. All flags and o_rdt read 0.
- Latency: a word written in cycle N is visible on o_valid/o_rdt in N+1. There is no same-cycle bypass, including when the queue is empty.
- Pop in cycle N: the next entry is presented in N+1. Flags are valid the same cycle as o_valid, with no extra stage in either PRE_REGISTER mode.
- Simultaneous push and pop: count unchanged. This holds at full, where the write is accepted.
- Single-entry queue with push+pop: o_valid stays 1 and the new word appears in N+1.
- Reset mid-stream: contents are abandoned, and the queue is empty the cycle after deassertion.
- Storage contents need no reset. Only control state is reset.

## Test plan
- Reset, then write 0x00000083>>2 (lw x1) at N with i_ready=0 -> N+1: o_valid=1, o_count=1, o_dbus_en=1, o_mem_cmd=0, o_rd_op=1, o_illegal=0.
- DEPTH=4: write 5 words back-to-back with i_ready=0 -> o_full=1 after the 4th; 5th dropped; o_overflow=1; head is still word 1.
- Full queue, i_wb_en & i_ready the same cycle -> o_count stays 4, o_overflow=0, head advances to word 2, and the new word is read out 4th.
- Three words queued, assert i_flush together with i_wb_en -> next cycle o_count=0, o_valid=0, o_overflow=0, all flags 0.
- MDU=0 vs MDU=1, write mul x1,x2,x3 (raw 0x023100B3) -> MDU=0: o_illegal=1, o_mdu_op=0; MDU=1: o_mdu_op=1, o_illegal=0. Write op=11111 -> o_illegal=1.
- Random push/pop/flush for 10k cycles, run with PRE_REGISTER=0 and =1 -> every popped word and its flags match a reference queue model, and both builds give identical port traces.
